spi_bus_arbiter: RTL and testbench

- Shares the single SPI memory engine between two requesters:
  - the instruction-fetch port (ROM device, 16-bit PC address);
  - the data port (RAM device, {mpage, mar} address, read or write).
- Sequences the engine's level-start / pulse-done handshake.
- Selects the target chip select and returns read data with a one-cycle acknowledge.
- Uses round-robin priority and includes a watchdog for engine hangs.

---
 rtl/spi_bus_arbiter_if.sv | 39 +++
 rtl/spi_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_spi_bus_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_arbiter_if.sv
// Signal bundle between the arbiter, the fetch/data requesters and the SPI engine.
// master: arbiter side. slave: requester/engine side.
interface spi_bus_arbiter_if;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ack;
  logic [7:0]  fetch_rdata;
  logic        data_req;
  logic        data_we;
  logic [15:0] data_addr;
  logic [7:0]  data_wdata;
  logic        data_ack;
  logic [7:0]  data_rdata;
  logic        spi_start;
  logic        spi_write;
  logic [15:0] spi_address;
  logic [7:0]  spi_wdata;
  logic [7:0]  spi_rdata;
  logic        spi_done;
  logic        sel_rom;
  logic        busy;
  logic        timeout_err;

  modport master (
    input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
           spi_rdata, spi_done,
    output fetch_ack, fetch_rdata, data_ack, data_rdata,
           spi_start, spi_write, spi_address, spi_wdata,
           sel_rom, busy, timeout_err
  );

  modport slave (
    output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
           spi_rdata, spi_done,
    input  fetch_ack, fetch_rdata, data_ack, data_rdata,
           spi_start, spi_write, spi_address, spi_wdata,
           sel_rom, busy, timeout_err
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI memory engine between the instruction-fetch
// port (ROM) and the data port (RAM), with a watchdog for engine hangs.
module spi_bus_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd2048,
  parameter int unsigned TW      = 12
) (
  input  logic              clk,
  input  logic              rst,
  spi_bus_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RECOVER = 2'd2} state_t;
  typedef enum logic {GRANT_DATA = 1'b0, GRANT_FETCH = 1'b1} grant_t;

  localparam logic          WD_EN   = (TIMEOUT != 16'd0);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 16'd1);

  state_t        state_q, state_d;
  grant_t        last_q, last_d;
  logic [TW-1:0] wd_q, wd_d;
  logic [15:0]   addr_q, addr_d;
  logic          write_q, write_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          sel_rom_q, sel_rom_d;
  logic          fetch_ack_q, fetch_ack_d;
  logic          data_ack_q, data_ack_d;
  logic [7:0]    fetch_rdata_q, fetch_rdata_d;
  logic [7:0]    data_rdata_q, data_rdata_d;
  logic          err_q, err_d;

  logic          grant_fetch;
  logic          wd_fire;
  logic [7:0]    done_byte;

  // Next-state: grant in IDLE, wait for done or watchdog in BUSY, one idle cycle in RECOVER.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    wd_d          = wd_q;
    addr_d        = addr_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    sel_rom_d     = sel_rom_q;
    fetch_ack_d   = 1'b0;
    data_ack_d    = 1'b0;
    fetch_rdata_d = fetch_rdata_q;
    data_rdata_d  = data_rdata_q;
    err_d         = err_q;

    grant_fetch = bus.fetch_req && (!bus.data_req || last_q == GRANT_DATA);
    wd_fire     = WD_EN && (wd_q == WD_LAST);
    // spi_done has priority over a simultaneous watchdog expiry.
    done_byte   = bus.spi_done ? bus.spi_rdata : 8'hFF;

    case (state_q)
      IDLE: begin
        if (bus.fetch_req || bus.data_req) begin
          wd_d    = '0;
          state_d = BUSY;
          if (grant_fetch) begin
            addr_d    = bus.fetch_addr;
            write_d   = 1'b0;
            wdata_d   = '0;
            sel_rom_d = 1'b1;
            last_d    = GRANT_FETCH;
          end else begin
            addr_d    = bus.data_addr;
            write_d   = bus.data_we;
            wdata_d   = bus.data_wdata;
            sel_rom_d = 1'b0;
            last_d    = GRANT_DATA;
          end
        end
      end
      BUSY: begin
        wd_d = wd_q + TW'(1);
        if (bus.spi_done || wd_fire) begin
          state_d = RECOVER;
          err_d   = err_q | ~bus.spi_done;
          if (sel_rom_q) begin
            fetch_ack_d   = 1'b1;
            fetch_rdata_d = done_byte;
          end else begin
            data_ack_d = 1'b1;
            if (!write_q || !bus.spi_done) data_rdata_d = done_byte;
          end
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; async reset drops spi_start immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= GRANT_DATA;
      wd_q          <= '0;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      sel_rom_q     <= 1'b1;
      fetch_ack_q   <= 1'b0;
      data_ack_q    <= 1'b0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      wd_q          <= wd_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      sel_rom_q     <= sel_rom_d;
      fetch_ack_q   <= fetch_ack_d;
      data_ack_q    <= data_ack_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_rdata_q  <= data_rdata_d;
      err_q         <= err_d;
    end
  end

  assign bus.spi_start   = (state_q == BUSY);
  assign bus.busy        = (state_q != IDLE);
  assign bus.spi_write   = write_q;
  assign bus.spi_address = addr_q;
  assign bus.spi_wdata   = wdata_q;
  assign bus.sel_rom     = sel_rom_q;
  assign bus.fetch_ack   = fetch_ack_q;
  assign bus.fetch_rdata = fetch_rdata_q;
  assign bus.data_ack    = data_ack_q;
  assign bus.data_rdata  = data_rdata_q;
  assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: default-timeout instance plus a
// TIMEOUT=16 instance for the watchdog, driven through one shared stimulus set.
module tb_spi_bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  spi_bus_arbiter_if bif();
  spi_bus_arbiter_if wif();

  spi_bus_arbiter #(.TIMEOUT(16'd2048), .TW(12)) dut    (.clk(clk), .rst(rst), .bus(bif));
  spi_bus_arbiter #(.TIMEOUT(16'd16),   .TW(5))  dut_wd (.clk(clk), .rst(rst), .bus(wif));

  // Stimulus, routed to whichever instance is active.
  logic        use_wd = 1'b0;
  logic        t_freq = 1'b0, t_dreq = 1'b0, t_dwe = 1'b0, t_done = 1'b0;
  logic [15:0] t_faddr = '0, t_daddr = '0;
  logic [7:0]  t_dwdata = '0, t_rdata = '0;

  assign bif.fetch_req  = t_freq & ~use_wd;
  assign wif.fetch_req  = t_freq & use_wd;
  assign bif.data_req   = t_dreq & ~use_wd;
  assign wif.data_req   = t_dreq & use_wd;
  assign bif.spi_done   = t_done & ~use_wd;
  assign wif.spi_done   = t_done & use_wd;
  assign bif.fetch_addr = t_faddr;
  assign wif.fetch_addr = t_faddr;
  assign bif.data_addr  = t_daddr;
  assign wif.data_addr  = t_daddr;
  assign bif.data_we    = t_dwe;
  assign wif.data_we    = t_dwe;
  assign bif.data_wdata = t_dwdata;
  assign wif.data_wdata = t_dwdata;
  assign bif.spi_rdata  = t_rdata;
  assign wif.spi_rdata  = t_rdata;

  logic        o_fack, o_dack, o_start, o_wr, o_sel, o_busy, o_err;
  logic [7:0]  o_frd, o_drd, o_wd;
  logic [15:0] o_addr;
  assign o_fack  = use_wd ? wif.fetch_ack   : bif.fetch_ack;
  assign o_dack  = use_wd ? wif.data_ack    : bif.data_ack;
  assign o_frd   = use_wd ? wif.fetch_rdata : bif.fetch_rdata;
  assign o_drd   = use_wd ? wif.data_rdata  : bif.data_rdata;
  assign o_start = use_wd ? wif.spi_start   : bif.spi_start;
  assign o_wr    = use_wd ? wif.spi_write   : bif.spi_write;
  assign o_addr  = use_wd ? wif.spi_address : bif.spi_address;
  assign o_wd    = use_wd ? wif.spi_wdata   : bif.spi_wdata;
  assign o_sel   = use_wd ? wif.sel_rom     : bif.sel_rom;
  assign o_busy  = use_wd ? wif.busy        : bif.busy;
  assign o_err   = use_wd ? wif.timeout_err : bif.timeout_err;

  // Reference model: round-robin memory plus per-port read registers.
  bit         mdl_last;   // 1 = fetch granted last
  logic [7:0] mdl_frd, mdl_drd;

  function automatic bit pick_fetch(input bit f, input bit d);
    if (f && !d) return 1'b1;
    if (d && !f) return 1'b0;
    return !mdl_last;
  endfunction

  typedef struct packed {
    int          waitc;
    int          starts;
    int          extra;
    logic        sel;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic        stable;
    logic        fa;
    logic        da;
    logic [7:0]  frd;
    logic [7:0]  drd;
    logic        busy_ack;
    logic        busy_after;
    logic        err;
  } obs_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Engine model: waits for spi_start, pulses done after lat cycles (lat=0: never),
  // and records what the arbiter showed. Does no comparing itself.
  task automatic engine(input int lat, input logic [7:0] rd, input bit drop,
                        input bit scramble, output obs_t o);
    o = '0;
    o.stable = 1'b1;
    while (!o_start && o.waitc < 8) begin
      step();
      o.waitc++;
    end
    if (!o_start) begin
      o.waitc = -1;
      return;
    end
    o.sel = o_sel; o.wr = o_wr; o.addr = o_addr; o.wd = o_wd;
    while (o_start && o.starts < 5000) begin
      o.starts++;
      if (o_fack || o_dack) o.extra++;
      if (o_sel !== o.sel || o_wr !== o.wr || o_addr !== o.addr || o_wd !== o.wd) o.stable = 1'b0;
      if (scramble) begin
        t_faddr = 16'($urandom); t_daddr = 16'($urandom);
        t_dwdata = 8'($urandom); t_dwe = 1'($urandom);
      end
      if (o.starts == lat) begin t_done = 1'b1; t_rdata = rd; end
      step();
      t_done = 1'b0; t_rdata = 8'($urandom);
    end
    if (o_sel !== o.sel || o_addr !== o.addr) o.stable = 1'b0;
    o.fa = o_fack; o.da = o_dack; o.frd = o_frd; o.drd = o_drd;
    o.busy_ack = o_busy; o.err = o_err;
    if (drop) begin t_freq = 1'b0; t_dreq = 1'b0; end
    step();
    if (o_fack || o_dack) o.extra++;
    o.busy_after = o_busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (o_start !== 1'b0) begin failures++; $display("FAIL reset_spi_start got=%b exp=0", o_start); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_sel !== 1'b1) begin failures++; $display("FAIL reset_sel_rom got=%b exp=1", o_sel); end
    checks++; if ({o_fack, o_dack, o_wr, o_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {o_fack, o_dack, o_wr, o_err}); end
    checks++; if ({o_addr, o_wd, o_frd, o_drd} !== 40'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {o_addr, o_wd, o_frd, o_drd}); end
    rst = 1'b0;
    mdl_last = 1'b0; mdl_frd = '0; mdl_drd = '0;
    step();
  endtask

  task automatic test_stray_done();
    t_done = 1'b1; t_rdata = 8'h5A;
    step();
    t_done = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      checks++; if ({o_busy, o_fack, o_dack, o_start} !== 4'b0) begin failures++; $display("FAIL stray_done got=%b exp=0000", {o_busy, o_fack, o_dack, o_start}); end
      step();
    end
  endtask

  task automatic test_single_fetch();
    obs_t o;
    t_faddr = 16'h0010; t_freq = 1'b1;
    engine(20, 8'hA5, 1'b1, 1'b0, o);
    mdl_last = 1'b1; mdl_frd = 8'hA5;
    checks++; if (o.waitc !== 1) begin failures++; $display("FAIL fetch_latency got=%0d exp=1", o.waitc); end
    checks++; if (o.starts !== 20) begin failures++; $display("FAIL fetch_start_len got=%0d exp=20", o.starts); end
    checks++; if ({o.sel, o.wr} !== 2'b10) begin failures++; $display("FAIL fetch_sel_wr got=%b exp=10", {o.sel, o.wr}); end
    checks++; if (o.addr !== 16'h0010) begin failures++; $display("FAIL fetch_addr got=%h exp=0010", o.addr); end
    checks++; if ({o.fa, o.da} !== 2'b10) begin failures++; $display("FAIL fetch_ack got=%b exp=10", {o.fa, o.da}); end
    checks++; if (o.frd !== 8'hA5) begin failures++; $display("FAIL fetch_rdata got=%h exp=a5", o.frd); end
    checks++; if ({o.extra, o.busy_ack, o.busy_after} !== {32'd0, 1'b1, 1'b0}) begin failures++; $display("FAIL fetch_tail got=%0d/%b/%b exp=0/1/0", o.extra, o.busy_ack, o.busy_after); end
  endtask

  task automatic test_data_write();
    obs_t o;
    logic [7:0] rd1;
    rd1 = 8'($urandom_range(0, 254));
    t_dwe = 1'b0; t_daddr = 16'($urandom); t_dreq = 1'b1;
    engine(int'($urandom_range(1, 10)), rd1, 1'b1, 1'b0, o);
    mdl_last = 1'b0; mdl_drd = rd1;
    checks++; if ({o.da, o.drd} !== {1'b1, rd1}) begin failures++; $display("FAIL data_read got=%b/%h exp=1/%h", o.da, o.drd, rd1); end
    t_dwe = 1'b1; t_daddr = 16'h0203; t_dwdata = 8'h3C; t_dreq = 1'b1;
    engine(int'($urandom_range(1, 10)), 8'h77, 1'b1, 1'b0, o);
    checks++; if ({o.wr, o.sel} !== 2'b10) begin failures++; $display("FAIL write_wr_sel got=%b exp=10", {o.wr, o.sel}); end
    checks++; if ({o.addr, o.wd} !== {16'h0203, 8'h3C}) begin failures++; $display("FAIL write_addr_wdata got=%h exp=02033c", {o.addr, o.wd}); end
    checks++; if ({o.fa, o.da, o.extra} !== {2'b01, 32'd0}) begin failures++; $display("FAIL write_ack got=%b/%0d exp=01/0", {o.fa, o.da}, o.extra); end
    checks++; if (o.drd !== mdl_drd) begin failures++; $display("FAIL write_rdata_kept got=%h exp=%h", o.drd, mdl_drd); end
    t_dwe = 1'b0;
  endtask

  task automatic test_random();
    obs_t o;
    for (int unsigned n = 0; n < 24; n++) begin
      int unsigned mode;
      int lat;
      bit ef, ewr;
      logic [15:0] eaddr;
      logic [7:0] ewd, rd;
      mode = $urandom_range(0, 2);
      t_faddr = 16'($urandom); t_daddr = 16'($urandom);
      t_dwe = 1'($urandom); t_dwdata = 8'($urandom);
      ef = pick_fetch(mode != 1, mode != 0);
      eaddr = ef ? t_faddr : t_daddr;
      ewr = ef ? 1'b0 : t_dwe;
      ewd = t_dwdata;
      lat = int'($urandom_range(1, 12));
      rd = 8'($urandom);
      t_freq = (mode != 1); t_dreq = (mode != 0);
      engine(lat, rd, 1'b1, $urandom_range(0, 1) == 1, o);
      mdl_last = ef;
      if (ef) mdl_frd = rd;
      else if (!ewr) mdl_drd = rd;
      checks++; if (o.waitc !== 1 || o.starts !== lat) begin failures++; $display("FAIL rnd_timing n=%0d got=%0d/%0d exp=1/%0d", n, o.waitc, o.starts, lat); end
      checks++; if ({o.sel, o.wr, o.addr} !== {ef, ewr, eaddr}) begin failures++; $display("FAIL rnd_grant n=%0d got=%b/%b/%h exp=%b/%b/%h", n, o.sel, o.wr, o.addr, ef, ewr, eaddr); end
      if (!ef) begin
        checks++; if (o.wd !== ewd) begin failures++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, o.wd, ewd); end
      end
      checks++; if (o.stable !== 1'b1) begin failures++; $display("FAIL rnd_stable n=%0d got=%b exp=1", n, o.stable); end
      checks++; if ({o.fa, o.da} !== {ef, !ef} || o.extra !== 0) begin failures++; $display("FAIL rnd_ack n=%0d got=%b/%0d exp=%b/0", n, {o.fa, o.da}, o.extra, {ef, !ef}); end
      checks++; if ({o.frd, o.drd} !== {mdl_frd, mdl_drd}) begin failures++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, {o.frd, o.drd}, {mdl_frd, mdl_drd}); end
      checks++; if ({o.busy_ack, o.busy_after, o.err} !== 3'b100) begin failures++; $display("FAIL rnd_busy_err n=%0d got=%b exp=100", n, {o.busy_ack, o.busy_after, o.err}); end
    end
  endtask

  task automatic test_input_stability();
    obs_t o;
    logic [15:0] a;
    a = 16'($urandom);
    t_faddr = a; t_freq = 1'b1;
    engine(15, 8'h3E, 1'b1, 1'b1, o);
    mdl_last = 1'b1; mdl_frd = 8'h3E;
    checks++; if (o.addr !== a || o.stable !== 1'b1) begin failures++; $display("FAIL stable_addr got=%h/%b exp=%h/1", o.addr, o.stable, a); end
    checks++; if (o.frd !== 8'h3E) begin failures++; $display("FAIL stable_rdata got=%h exp=3e", o.frd); end
  endtask

  task automatic test_contention();
    obs_t o;
    rst = 1'b1;
    t_freq = 1'b1; t_dreq = 1'b1; t_dwe = 1'b0;
    t_faddr = 16'($urandom); t_daddr = 16'($urandom);
    step(); step();
    rst = 1'b0;
    mdl_last = 1'b0; mdl_frd = '0; mdl_drd = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      bit ef;
      logic [7:0] rd;
      ef = pick_fetch(1'b1, 1'b1);
      rd = 8'($urandom);
      engine(int'($urandom_range(1, 8)), rd, i == 3, 1'b0, o);
      mdl_last = ef;
      if (ef) mdl_frd = rd; else mdl_drd = rd;
      checks++; if (o.waitc !== 1 || o.sel !== ef) begin failures++; $display("FAIL cont_grant i=%0d got=%0d/%b exp=1/%b", i, o.waitc, o.sel, ef); end
      checks++; if ({o.fa, o.da} !== {ef, !ef} || o.extra !== 0) begin failures++; $display("FAIL cont_ack i=%0d got=%b/%0d exp=%b/0", i, {o.fa, o.da}, o.extra, {ef, !ef}); end
      checks++; if ({o.frd, o.drd} !== {mdl_frd, mdl_drd}) begin failures++; $display("FAIL cont_rdata i=%0d got=%h exp=%h", i, {o.frd, o.drd}, {mdl_frd, mdl_drd}); end
    end
    step();
    checks++; if (o_start !== 1'b0) begin failures++; $display("FAIL cont_idle_after got=%b exp=0", o_start); end
  endtask

  task automatic test_reset_mid_busy();
    obs_t o;
    logic [7:0] rd;
    t_faddr = 16'($urandom); t_freq = 1'b1;
    step();
    checks++; if (o_start !== 1'b1) begin failures++; $display("FAIL rmb_start got=%b exp=1", o_start); end
    repeat (4) step();
    #2; rst = 1'b1; #1;
    checks++; if ({o_start, o_busy, o_sel, o_fack} !== 4'b0010) begin failures++; $display("FAIL rmb_async got=%b exp=0010", {o_start, o_busy, o_sel, o_fack}); end
    t_done = 1'b1; t_rdata = 8'h11;
    step();
    t_done = 1'b0;
    checks++; if (o_fack !== 1'b0) begin failures++; $display("FAIL rmb_no_ack got=%b exp=0", o_fack); end
    step();
    rst = 1'b0;
    mdl_last = 1'b0; mdl_frd = '0; mdl_drd = '0;
    checks++; if ({o_frd, o_err} !== 9'h0) begin failures++; $display("FAIL rmb_cleared got=%h exp=0", {o_frd, o_err}); end
    rd = 8'($urandom);
    engine(7, rd, 1'b1, 1'b0, o);
    mdl_last = 1'b1; mdl_frd = rd;
    checks++; if (o.waitc !== 1 || o.starts !== 7 || o.fa !== 1'b1 || o.frd !== rd) begin failures++; $display("FAIL rmb_after got=%0d/%0d/%b/%h exp=1/7/1/%h", o.waitc, o.starts, o.fa, o.frd, rd); end
  endtask

  task automatic test_watchdog();
    obs_t o;
    logic [7:0] rd;
    use_wd = 1'b1;
    step();
    rd = 8'($urandom_range(0, 254));
    t_dwe = 1'b0; t_daddr = 16'($urandom); t_dreq = 1'b1;
    engine(16, rd, 1'b1, 1'b0, o);
    checks++; if (o.starts !== 16 || o.da !== 1'b1 || o.drd !== rd || o.err !== 1'b0) begin failures++; $display("FAIL wd_done_wins got=%0d/%b/%h/%b exp=16/1/%h/0", o.starts, o.da, o.drd, o.err, rd); end
    t_daddr = 16'($urandom); t_dreq = 1'b1;
    engine(0, 8'h00, 1'b1, 1'b0, o);
    checks++; if (o.starts !== 16 || o.da !== 1'b1 || o.extra !== 0) begin failures++; $display("FAIL wd_abort got=%0d/%b/%0d exp=16/1/0", o.starts, o.da, o.extra); end
    checks++; if (o.drd !== 8'hFF || o.err !== 1'b1) begin failures++; $display("FAIL wd_abort_data got=%h/%b exp=ff/1", o.drd, o.err); end
    rd = 8'($urandom);
    t_faddr = 16'($urandom); t_freq = 1'b1;
    engine(5, rd, 1'b1, 1'b0, o);
    checks++; if (o.starts !== 5 || o.fa !== 1'b1 || o.frd !== rd) begin failures++; $display("FAIL wd_next got=%0d/%b/%h exp=5/1/%h", o.starts, o.fa, o.frd, rd); end
    repeat (3) step();
    checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL wd_sticky got=%b exp=1", o_err); end
    use_wd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stray_done();
    test_single_fetch();
    test_data_write();
    test_random();
    test_input_stability();
    test_contention();
    test_reset_mid_busy();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule
